// File: rtl/cordic_post_scale_pkg.sv
// Shared types and constants for the CORDIC output conditioning stage:
// Q16.16 word and product types, the rounding constant, and the gain and
// radian-to-degree scale tables.
package cordic_post_scale_pkg;

    localparam int SIZE_DATA = 16;
    localparam int SIZE_FRAC = 16;
    localparam int FULL_SIZE = SIZE_DATA + SIZE_FRAC;

    // Number of CORDIC iterations covered by the gain table
    localparam int STAGES_K    = 16;
    localparam int K_INDEX_DEF = STAGES_K - 1;

    typedef logic signed [FULL_SIZE-1:0]   q_word_t;
    typedef logic signed [2*FULL_SIZE-1:0] q_prod_t;

    // Half an LSB of the result, added before the arithmetic shift
    localparam int ROUND_HALF = 1 << (SIZE_FRAC - 1);

    // Inverse cumulative CORDIC gain after iteration i, unsigned Q16.16
    localparam logic [FULL_SIZE-1:0] K_SCALED [STAGES_K] = '{
        32'h0000_B505, 32'h0000_A1E8, 32'h0000_9D13, 32'h0000_9BDC,
        32'h0000_9B8F, 32'h0000_9B7B, 32'h0000_9B77, 32'h0000_9B75,
        32'h0000_9B75, 32'h0000_9B75, 32'h0000_9B75, 32'h0000_9B75,
        32'h0000_9B75, 32'h0000_9B75, 32'h0000_9B75, 32'h0000_9B75
    };

    // 180/pi in unsigned Q16.16
    localparam logic [FULL_SIZE-1:0] T_SCALED = 32'h0039_4BB8;

endpackage

// File: rtl/cordic_fixmul.sv
// Two-stage signed x unsigned-constant multiply: stage 1 registers the
// full-width product, stage 2 rounds half toward +inf, drops the fraction
// bits and saturates to the signed word range, flagging saturation.
module cordic_fixmul
    import cordic_post_scale_pkg::*;
#(
    parameter logic [FULL_SIZE-1:0] COEF = 32'h0001_0000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [FULL_SIZE-1:0] din,
    output logic [FULL_SIZE-1:0] dout,
    output logic                 sat
);

    // Limits of the signed word, expressed in the widened rounding domain
    localparam logic signed [2*FULL_SIZE:0] R_MAX =
        {{(FULL_SIZE+2){1'b0}}, {(FULL_SIZE-1){1'b1}}};
    localparam logic signed [2*FULL_SIZE:0] R_MIN =
        {{(FULL_SIZE+2){1'b1}}, {(FULL_SIZE-1){1'b0}}};
    localparam logic signed [2*FULL_SIZE:0] R_HALF = (2*FULL_SIZE+1)'(ROUND_HALF);

    q_prod_t                     prod_d, prod_q;
    logic [FULL_SIZE-1:0]        dout_d, dout_q;
    logic                        sat_d, sat_q;
    q_prod_t                     din_ext;
    q_prod_t                     coef_ext;
    logic signed [2*FULL_SIZE:0] rounded;

    // The constant carries a zero sign bit so it is always treated as positive;
    // the product magnitude stays below 2^63, so 64 bits hold it exactly.
    assign din_ext  = q_prod_t'($signed(din));
    assign coef_ext = q_prod_t'({1'b0, COEF});

    // Extra top bit keeps the rounding add from wrapping
    assign rounded = ($signed({prod_q[2*FULL_SIZE-1], prod_q}) + R_HALF) >>> SIZE_FRAC;

    // Next-state: product capture, then round and saturate, both gated by en
    always_comb begin
        prod_d = prod_q;
        dout_d = dout_q;
        sat_d  = sat_q;
        if (en) begin
            prod_d = din_ext * coef_ext;
            if (rounded > R_MAX) begin
                dout_d = {1'b0, {(FULL_SIZE-1){1'b1}}};
                sat_d  = 1'b1;
            end else if (rounded < R_MIN) begin
                dout_d = {1'b1, {(FULL_SIZE-1){1'b0}}};
                sat_d  = 1'b1;
            end else begin
                dout_d = rounded[FULL_SIZE-1:0];
                sat_d  = 1'b0;
            end
        end
    end

    // Pipeline registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_q <= '0;
            dout_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            prod_q <= prod_d;
            dout_q <= dout_d;
            sat_q  <= sat_d;
        end
    end

    assign dout = dout_q;
    assign sat  = sat_q;

endmodule

// File: rtl/cordic_post_scale.sv
// CORDIC output conditioning: removes the CORDIC gain from the magnitude and
// optionally converts the angle from radians to degrees, through a 2-stage
// stallable valid/ready pipeline.
// Option macro: CORDIC_DEGREES_EN -- when defined the angle is scaled to
// degrees (and can saturate); otherwise it passes through with equal latency.
module cordic_post_scale
    import cordic_post_scale_pkg::*;
#(
    parameter int K_INDEX = K_INDEX_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FULL_SIZE-1:0] in_x,
    input  logic [FULL_SIZE-1:0] in_z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FULL_SIZE-1:0] out_mag,
    output logic [FULL_SIZE-1:0] out_angle,
    output logic                 out_sat
);

    logic en;
    logic v1_d, v1_q;
    logic v2_d, v2_q;
    logic mag_sat;

    // The whole pipeline moves together whenever the output slot is free or draining
    assign en       = !v2_q || out_ready;
    assign in_ready = en;

    // Valid bits advance with the pipeline; bubbles travel as v=0
    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        if (en) begin
            v1_d = in_valid;
            v2_d = v1_q;
        end
    end

    // Valid pipeline registers; reset discards any in-flight beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end

    assign out_valid = v2_q;

    cordic_fixmul #(
        .COEF (K_SCALED[K_INDEX])
    ) u_mag (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .din     (in_x),
        .dout    (out_mag),
        .sat     (mag_sat)
    );

`ifdef CORDIC_DEGREES_EN
    logic ang_sat;

    cordic_fixmul #(
        .COEF (T_SCALED)
    ) u_ang (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .din     (in_z),
        .dout    (out_angle),
        .sat     (ang_sat)
    );

    assign out_sat = mag_sat | ang_sat;
`else
    logic [FULL_SIZE-1:0] z1_d, z1_q;
    logic [FULL_SIZE-1:0] z2_d, z2_q;

    // Radian angle delay line matching the multiplier latency
    always_comb begin
        z1_d = z1_q;
        z2_d = z2_q;
        if (en) begin
            z1_d = in_z;
            z2_d = z1_q;
        end
    end

    // Angle delay registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            z1_q <= '0;
            z2_q <= '0;
        end else begin
            z1_q <= z1_d;
            z2_q <= z2_d;
        end
    end

    assign out_angle = z2_q;
    assign out_sat   = mag_sat;
`endif

endmodule

// File: doc/cordic_post_scale.md
# cordic_post_scale

Output conditioning stage placed directly downstream of the CORDIC vectoring core. It accepts the raw core results as Q16.16 words: an x-magnitude still carrying the CORDIC gain, and a z-angle in radians. It removes the gain by multiplying by a selected K_SCALED entry and, optionally, converts the angle to degrees with T_SCALED. Both results pass through a 2-stage stallable pipeline with valid/ready handshakes on both sides.

## Interface
- SIZE_DATA, 16, integer bits of the Q format
- SIZE_FRAC, 16, fractional bits of the Q format
- FULL_SIZE, SIZE_DATA+SIZE_FRAC, word width
- K_INDEX, STAGES_K-1, index into K_SCALED; legal range 0..STAGES_K-1, elaborated once
- clk  input  1  sole clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream beat present
- in_ready  output  1  stage accepts a beat this cycle
- in_x  input  FULL_SIZE  signed Q16.16 raw magnitude
- in_z  input  FULL_SIZE  signed Q16.16 angle, radians
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts
- out_mag  output  FULL_SIZE  signed Q16.16 gain-corrected magnitude
- out_angle  output  FULL_SIZE  signed Q16.16 angle (degrees or radians, see Configuration)
- out_sat  output  1  a saturation occurred on either result of this beat

## Operation
- Global advance: en = !out_valid || out_ready. in_ready = en (combinational from out_ready and out_valid).
- A beat transfers when in_valid && in_ready. An output beat transfers when out_valid && out_ready.
- Stage 1 (on en): register v1 <= in_valid. Compute and register full-width products:
  - p_mag = in_x (signed) × K_SCALED[K_INDEX], with a zero sign bit appended to K; 2*FULL_SIZE bits.
  - p_ang = in_z × T_SCALED, formed the same way.
- Stage 2 (on en): register v2 <= v1 and compute each result as r = (p + 2^(SIZE_FRAC-1)) >>> SIZE_FRAC. This is round-half-toward-+inf.
  - If r is outside the signed FULL_SIZE range, saturate to 0x7FFF_FFFF or 0x8000_0000.
  - out_sat = OR of the two saturation events.
- out_valid = v2. Outputs hold stable while out_valid && !out_ready.
- When en is low, data registers do not change. Bubbles (v=0) move through; their data content is don't-care.
- Reset: v1, v2, out_valid, out_sat, out_mag and out_angle all go to 0 immediately on reset_n low. In-flight beats are discarded.

## Timing
- Latency: 2 cycles from input transfer to out_valid when out_ready is held high. Throughput: 1 beat/cycle.
- Stall: with out_valid=1 and out_ready=0, in_ready=0 in the same cycle. No beat is lost or duplicated.
- Simultaneous output drain and input accept in one cycle is legal and sustains full rate.
- Reset release: the first accept is possible in the cycle after reset_n rises. in_ready=1 out of reset.

## Configuration
- CORDIC_DEGREES_EN defined: out_angle = in_z × T_SCALED, rounded and saturated as above, in Q16.16 degrees.
- CORDIC_DEGREES_EN undefined: out_angle = in_z passed through unchanged in radians.
  - The same 2-cycle latency is kept.
  - The angle multiplier is not built.
  - out_sat reflects only the magnitude path.

## Structure
- Shared package holds:
  - the Q16.16 signed word typedef and the 2×FULL_SIZE product typedef
  - ROUND_HALF = 1 << (SIZE_FRAC-1)
  - the default K_INDEX constant
  - the existing K_SCALED and T_SCALED tables
- One sub-module, cordic_fixmul: registered signed×unsigned-constant multiply, followed by the round/saturate stage and a sat flag. It is instantiated for the magnitude path, and for the angle path under CORDIC_DEGREES_EN. The top-level block owns the handshake and valid pipeline.

## Test plan
- Magnitude gain correction: K_INDEX=8, in_x=0x0001_0000 -> out_mag=0x0000_9B75 two cycles later, out_sat=0.
- Angle conversion (macro on): in_z=0x0001_921F (π/2) -> out_angle=0x0059_FFD7. in_z=0xFFFF_0000 -> out_angle=0xFFC6_B448.
- Saturation (macro on): in_z=0x7FFF_0000 -> out_angle=0x7FFF_FFFF, out_sat=1. in_z=0x8000_0000 -> 0x8000_0000, out_sat=1.
- Backpressure: stream 5 beats with out_ready low for 3 cycles mid-stream -> in_ready mirrors the stall, outputs are held stable, and all 5 results emerge in order exactly once.
- Reset mid-flight: drop reset_n while 2 beats are in the pipe -> out_valid=0 immediately. After release, no stale beat appears and the next input emerges 2 cycles after acceptance.
- Macro off: in_z=0x1234_5678 -> out_angle=0x1234_5678 at latency 2, out_sat=0.
